// File: rtl/intr_sequencer.sv
// Interrupt entry/exit sequencer for the 8-bit pipelined CPU: latches INTR_in edges, saves
// PC and flags on the stack, vectors to the ISR, and restores both on RTI.
module intr_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(8'h01)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INTR_in,
  input  logic              mem_busy,
  input  logic              branch_pending,
  input  logic              rti_decoded,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic [3:0]        flags_in,
  input  logic [ADDR_W-1:0] sp,
  input  logic [7:0]        mem_rdata,
  output logic              stall_fetch,
  output logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              sp_dec,
  output logic              sp_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              flags_restore,
  output logic [3:0]        flags_out,
  output logic              in_service,
  output logic              intr_pending
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_FLUSH, S_PUSH_PC, S_PUSH_F,
    S_VEC_RD, S_VEC_LD, S_RTI_A, S_RTI_B, S_RTI_C
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              intr_prev;
  logic              intr_rise;
  logic [ADDR_W-1:0] ret_pc;
  logic [3:0]        ret_f;
  logic [ADDR_W-1:0] sp_plus1;

  assign intr_rise = INTR_in & ~intr_prev;
  assign sp_plus1  = sp + ADDR_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (intr_pending && !in_service)    state_nxt = S_WAIT;
        else if (rti_decoded && in_service) state_nxt = S_RTI_A;
      end
      S_WAIT:    if (!mem_busy && !branch_pending) state_nxt = S_FLUSH;
      S_FLUSH:   state_nxt = S_PUSH_PC;
      S_PUSH_PC: state_nxt = S_PUSH_F;
      S_PUSH_F:  state_nxt = S_VEC_RD;
      S_VEC_RD:  state_nxt = S_VEC_LD;
      S_VEC_LD:  state_nxt = S_IDLE;
      S_RTI_A:   state_nxt = S_RTI_B;
      S_RTI_B:   state_nxt = S_RTI_C;
      S_RTI_C:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Control strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= S_IDLE;
      intr_prev     <= 1'b0;
      intr_pending  <= 1'b0;
      in_service    <= 1'b0;
      ret_pc        <= '0;
      ret_f         <= '0;
      stall_fetch   <= 1'b0;
      flush         <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      sp_dec        <= 1'b0;
      sp_inc        <= 1'b0;
      pc_load       <= 1'b0;
      flags_restore <= 1'b0;
    end else begin
      state     <= state_nxt;
      intr_prev <= INTR_in;

      // One-deep request latch: an edge arriving while already pending is dropped.
      if (state == S_VEC_LD)  intr_pending <= 1'b0;
      else if (intr_rise)     intr_pending <= 1'b1;

      if (state == S_VEC_LD)     in_service <= 1'b1;
      else if (state == S_RTI_C) in_service <= 1'b0;

      if (state == S_FLUSH) begin
        ret_pc <= pc_next;
        ret_f  <= flags_in;
      end

      stall_fetch   <= state_nxt inside {S_WAIT, S_FLUSH, S_PUSH_PC, S_PUSH_F,
                                         S_VEC_RD, S_RTI_A, S_RTI_B};
      flush         <= state_nxt inside {S_FLUSH, S_RTI_A};
      mem_req       <= state_nxt inside {S_PUSH_PC, S_PUSH_F, S_VEC_RD, S_RTI_A, S_RTI_B};
      mem_we        <= state_nxt inside {S_PUSH_PC, S_PUSH_F};
      sp_dec        <= state_nxt inside {S_PUSH_PC, S_PUSH_F};
      sp_inc        <= state_nxt inside {S_RTI_A, S_RTI_B};
      pc_load       <= state_nxt inside {S_VEC_LD, S_RTI_C};
      flags_restore <= state_nxt == S_RTI_B;
    end
  end

  // Address and data follow the live SP and read-data bus; zero outside their states.
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    pc_load_val = '0;
    flags_out   = '0;
    case (state)
      S_PUSH_PC: begin
        mem_addr  = sp;
        mem_wdata = 8'(ret_pc);
      end
      S_PUSH_F: begin
        mem_addr  = sp;
        mem_wdata = {4'b0000, ret_f};
      end
      S_VEC_RD: mem_addr = VEC_ADDR;
      S_RTI_A:  mem_addr = sp_plus1;
      S_RTI_B: begin
        mem_addr  = sp_plus1;
        flags_out = mem_rdata[3:0];
      end
      S_VEC_LD, S_RTI_C: pc_load_val = ADDR_W'(mem_rdata);
      default: ;
    endcase
  end

endmodule
